// File: rtl/alut_mem_ctrl14.sv
// alut_mem_ctrl14 -- dual-port table memory for the ALUT address and age checkers.
// Port A serves the address checker and port B the age checker. After reset, and
// again on a software init request, a sweep writes INIT_VAL to every entry, one
// entry per cycle. Port accesses are dropped while the sweep runs.
// If both ports write the same entry in one cycle, port A wins and coll_err14 pulses.
// Optional feature macro: ALUT_MEM_BYPASS_EN. When it is defined, a read of an entry
// that the opposite port writes in the same cycle returns the new write data.
// Without it, that read returns the old contents.
module alut_mem_ctrl14 #(
  parameter int            DW       = 83,
  parameter int            AW       = 8,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          pclk14,
  input  logic          p_reset14,
  input  logic          init_req14,
  input  logic          a_en14,
  input  logic          a_wr14,
  input  logic [AW-1:0] a_addr14,
  input  logic [DW-1:0] a_wdata14,
  output logic [DW-1:0] a_rdata14,
  output logic          a_rvalid14,
  input  logic          b_en14,
  input  logic          b_wr14,
  input  logic [AW-1:0] b_addr14,
  input  logic [DW-1:0] b_wdata14,
  output logic [DW-1:0] b_rdata14,
  output logic          b_rvalid14,
  output logic          init_busy14,
  output logic          coll_err14
);

  localparam int DD = 2 ** AW;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [AW-1:0] LAST_PTR = AW'(DD - 1);

  logic [DW-1:0] mem_q [DD];

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic          coll_q, coll_d;

  logic          isReady;
  logic          aWriteEn, bWriteEn;
  logic          aReadEn, bReadEn;
  logic          sameAddr;
  logic [DW-1:0] aReadData, bReadData;

  // Qualify the port requests. Nothing gets through during a sweep or while reset is held.
  always_comb begin
    isReady  = (state_q == ST_READY) && !p_reset14;
    aWriteEn = isReady && a_en14 && a_wr14;
    bWriteEn = isReady && b_en14 && b_wr14;
    aReadEn  = isReady && a_en14 && !a_wr14;
    bReadEn  = isReady && b_en14 && !b_wr14;
    sameAddr = (a_addr14 == b_addr14);
  end

  // Pick the read data. Optionally forward the opposite port's same-cycle write.
  always_comb begin
    aReadData = mem_q[a_addr14];
    bReadData = mem_q[b_addr14];
`ifdef ALUT_MEM_BYPASS_EN
    if (bWriteEn && sameAddr) begin
      aReadData = b_wdata14;
    end
    if (aWriteEn && sameAddr) begin
      bReadData = a_wdata14;
    end
`endif
  end

  // Sweep sequencing. INIT walks ptr to the last entry, and READY waits for init_req14.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        if (ptr_q == LAST_PTR) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_READY: begin
        if (init_req14) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Next values of the read ports and the collision flag. The read data holds when there is no read.
  always_comb begin
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = aReadEn;
    b_rvalid_d = bReadEn;
    coll_d     = aWriteEn && bWriteEn && sameAddr;
    if (aReadEn) begin
      a_rdata_d = aReadData;
    end
    if (bReadEn) begin
      b_rdata_d = bReadData;
    end
  end

  // Control and output registers. Reset restarts the sweep from entry 0.
  always_ff @(posedge pclk14) begin
    if (p_reset14) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      coll_q     <= coll_d;
    end
  end

  // Array writes. The port-A write comes last, so it wins a same-address collision.
  always_ff @(posedge pclk14) begin
    if (!p_reset14) begin
      if (state_q == ST_INIT) begin
        mem_q[ptr_q] <= INIT_VAL;
      end else begin
        if (bWriteEn) begin
          mem_q[b_addr14] <= b_wdata14;
        end
        if (aWriteEn) begin
          mem_q[a_addr14] <= a_wdata14;
        end
      end
    end
  end

  assign a_rdata14   = a_rdata_q;
  assign b_rdata14   = b_rdata_q;
  assign a_rvalid14  = a_rvalid_q;
  assign b_rvalid14  = b_rvalid_q;
  assign coll_err14  = coll_q;
  assign init_busy14 = (state_q == ST_INIT);

endmodule

// File: doc/alut_mem_ctrl14.md
ALUT_MEM_CTRL14 -- requirements
Module: alut_mem_ctrl14

Interface
REQ-001 Parameter DW, default 83, data width in bits.
REQ-002 Parameter AW, default 8, address width; depth DD = 2**AW.
REQ-003 Parameter INIT_VAL, default 0 (DW bits), value written to every entry by the clear sweep.
REQ-004 The clock is pclk14, input, 1 bit; all logic SHALL be clocked on its rising edge.
REQ-005 The reset is p_reset14, input, 1 bit; it SHALL be synchronous and active-high.
REQ-006 Port init_req14, input, 1 bit, requests a software-triggered clear sweep.
REQ-007 Port a_en14, input, 1 bit, enables a port-A (address checker) access.
REQ-008 Port a_wr14, input, 1 bit, selects the port-A operation: 1 = write, 0 = read.
REQ-009 Port a_addr14, input, AW bits, port-A entry address.
REQ-010 Port a_wdata14, input, DW bits, port-A write data.
REQ-011 Port a_rdata14, output, DW bits, port-A read data.
REQ-012 Port a_rvalid14, output, 1 bit, qualifies a_rdata14 for one cycle.
REQ-013 Ports b_en14, b_wr14, b_addr14, b_wdata14, b_rdata14 and b_rvalid14 SHALL mirror the port-A ports for the port-B (age checker) side.
REQ-014 Port init_busy14, output, 1 bit, SHALL be high while a clear sweep is in progress.
REQ-015 Port coll_err14, output, 1 bit, pulses on a same-address write-write collision.

Function
REQ-016 The state machine SHALL have two states, INIT and READY; reset SHALL enter INIT with the sweep pointer at 0.
- INIT: write INIT_VAL to entry ptr, then ptr+1; after entry DD-1, go to READY. Sweep takes exactly DD cycles.
- READY: init_req14 = 1 SHALL go to INIT with ptr = 0 on the next cycle.
- init_req14 during INIT SHALL be ignored.
REQ-017 init_busy14 SHALL equal (state == INIT), registered.
REQ-018 In INIT, port accesses SHALL be dropped: no array write, and a_rvalid14 and b_rvalid14 SHALL be 0.
REQ-019 A read in READY (xx_en14 = 1, xx_wr14 = 0) SHALL return array data on xx_rdata14 one cycle later, with xx_rvalid14 = 1 for that one cycle.
REQ-020 xx_rdata14 SHALL hold its last value when no read is issued; xx_rvalid14 SHALL be 0.
REQ-021 A write in READY SHALL update the array at the clock edge; xx_rvalid14 SHALL stay 0.
REQ-022 If both ports write the same address in one cycle, port A SHALL win, port-B data SHALL be discarded, and coll_err14 SHALL be 1 the next cycle for one cycle.
REQ-023 Writes by both ports to different addresses in one cycle SHALL both complete.
REQ-024 Reads by both ports of the same address SHALL return identical data.
REQ-025 Read and write of the same address by opposite ports in one cycle SHALL follow the REQ-041/REQ-042 configuration.
REQ-026 The address SHALL be used modulo DD; no out-of-range condition exists.

Reset
REQ-027 On p_reset14 = 1 at a clock edge, the following SHALL become 0: a_rdata14, b_rdata14, a_rvalid14, b_rvalid14 and coll_err14.
REQ-028 On that edge, init_busy14 SHALL become 1 and the state SHALL become INIT with ptr = 0.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep from entry 0.
REQ-030 Reset asserted mid-sweep SHALL NOT shorten the sweep; a full DD cycles SHALL follow the release of reset.
REQ-031 Array contents SHALL NOT be reset directly; they are defined only through the sweep.

Configuration
REQ-041 With macro ALUT_MEM_BYPASS_EN defined, a read of an address that the opposite port writes in the same cycle SHALL return the new write data.
REQ-042 Without ALUT_MEM_BYPASS_EN, that read SHALL return the pre-write (old) array contents.

Verification
REQ-051 Scenario: release reset, DW = 83, AW = 8 -> init_busy14 is high for exactly 256 cycles, then low; reads of addresses 0x00 and 0xFF return 0.
REQ-052 Scenario: port-A write 0x0AB to 0x10, then port-B read of 0x10 -> b_rdata14 = 0x0AB and b_rvalid14 = 1 exactly one cycle after the read.
REQ-053 Scenario: same-cycle writes to 0x20, A = 0x111 and B = 0x222 -> coll_err14 pulses once; a later read of 0x20 returns 0x111.
REQ-054 Scenario: port-A write 0x5 to 0x30 while port B reads 0x30 (old value 0x1):
- with ALUT_MEM_BYPASS_EN defined -> b_rdata14 = 0x5;
- without it -> b_rdata14 = 0x1.
REQ-055 Scenario: init_req14 in READY after writing 0x7 to 0x40 -> 256-cycle sweep; accesses during the sweep are ignored with rvalid = 0; afterwards a read of 0x40 returns 0.
REQ-056 Scenario: p_reset14 asserted at sweep cycle 100 -> ptr returns to 0, and init_busy14 stays high for 256 cycles after reset is released.
